// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard control for a 5-stage MIPS pipeline.
// Shadows EX/MEM destination info and registers the EX-stage mux selects.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic                  stall_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  idex_bubble_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  rs_hit, rt_hit, bubble;
  logic [1:0]            sel_a, sel_b;

  // Load in EX feeding a source read in ID; a taken flush overrides it.
  always_comb begin
    rs_hit  = id_uses_rs_i && (id_rs_i == ex_rd_q);
    rt_hit  = id_uses_rt_i && (id_rt_i == ex_rd_q);
    stall_o = id_valid_i && !flush_i && ex_mr_q &&
              (ex_rd_q != '0) && (rs_hit || rt_hit);
    bubble  = stall_o || flush_i;
  end

  assign pc_write_o    = ~stall_o;
  assign ifid_write_o  = ~stall_o;
  assign idex_bubble_o = bubble;

  // Select the newest producer of each source; $0 is never forwarded.
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (id_uses_rs_i && id_rs_i != '0) begin
      if (ex_rw_q && ex_rd_q == id_rs_i)        sel_a = 2'b01;
      else if (mem_rw_q && mem_rd_q == id_rs_i) sel_a = 2'b10;
    end
    if (id_uses_rt_i && id_rt_i != '0) begin
      if (ex_rw_q && ex_rd_q == id_rt_i)        sel_b = 2'b01;
      else if (mem_rw_q && mem_rd_q == id_rt_i) sel_b = 2'b10;
    end
  end

  // Advance the tracking slots, selects and stall counter.
  always_comb begin
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;
    ex_rd_d  = '0;
    ex_rw_d  = 1'b0;
    ex_mr_d  = 1'b0;
    fwd_a_d  = 2'b00;
    fwd_b_d  = 2'b00;
    cnt_d    = cnt_q;
    if (!bubble) begin
      ex_rd_d = id_rd_i;
      ex_rw_d = id_regwrite_i & id_valid_i;
      ex_mr_d = id_memread_i & id_valid_i;
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end
    if (stall_o && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios plus random
// instruction streams against an in-flight-instruction reference model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, urs, urt, rw, mr, fl;
  logic [4:0] rs, rt, rd;

  logic [1:0]  fa, fb, fa2, fb2;
  logic        st, pcw, ifw, bub, st2, pcw2, ifw2, bub2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(v),
    .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .id_rd_i(rd), .id_regwrite_i(rw), .id_memread_i(mr),
    .flush_i(fl),
    .fwd_a_sel_o(fa), .fwd_b_sel_o(fb), .stall_o(st),
    .pc_write_o(pcw), .ifid_write_o(ifw),
    .idex_bubble_o(bub), .stall_cnt_o(cnt)
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(v),
    .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .id_rd_i(rd), .id_regwrite_i(rw), .id_memread_i(mr),
    .flush_i(fl),
    .fwd_a_sel_o(fa2), .fwd_b_sel_o(fb2), .stall_o(st2),
    .pc_write_o(pcw2), .ifid_write_o(ifw2),
    .idex_bubble_o(bub2), .stall_cnt_o(cnt2)
  );

  // One in-flight instruction: destination, writes-reg, is-load.
  typedef struct {
    int dst;
    bit wr;
    bit ld;
  } instr_t;

  // pipe[0] is the instruction now in EX, pipe[1] the one in MEM.
  instr_t pipe [2];
  int     m_fa, m_fb;
  longint m_stalls;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int src_sel(input bit uses, input int src);
    if (!uses || src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (pipe[age].wr && pipe[age].dst == src) return age + 1;
    return 0;
  endfunction

  function automatic bit load_hazard(input bit vv, input bit ff,
                                     input bit ua, input int a,
                                     input bit ub, input int b);
    if (!vv || ff) return 0;
    if (!pipe[0].ld || pipe[0].dst == 0) return 0;
    return (ua && a == pipe[0].dst) || (ub && b == pipe[0].dst);
  endfunction

  function automatic int sat(input longint n, input longint mx);
    return int'((n > mx) ? mx : n);
  endfunction

  // One ID cycle: drive, check 0-latency outputs, clock, check registered.
  task automatic step(input bit iv, input int irs, input bit iurs,
                      input int irt, input bit iurt, input int ird,
                      input bit irw, input bit imr, input bit ifl,
                      input bit irst);
    bit     exp_st, exp_bub;
    int     na, nb;
    instr_t nx;
    v = iv; rs = 5'(irs); urs = iurs; rt = 5'(irt); urt = iurt;
    rd = 5'(ird); rw = irw; mr = imr; fl = ifl; rst = irst;
    #1;
    exp_st  = load_hazard(iv, ifl, iurs, irs, iurt, irt);
    exp_bub = exp_st || ifl;
    chk("stall", int'(st), int'(exp_st));
    chk("pc_write", int'(pcw), int'(!exp_st));
    chk("ifid_write", int'(ifw), int'(!exp_st));
    chk("bubble", int'(bub), int'(exp_bub));
    chk("stall_w2", int'(st2), int'(exp_st));
    na = exp_bub ? 0 : src_sel(iurs, irs);
    nb = exp_bub ? 0 : src_sel(iurt, irt);
    nx.dst = exp_bub ? 0 : ird;
    nx.wr  = !exp_bub && irw && iv;
    nx.ld  = !exp_bub && imr && iv;
    @(posedge clk);
    if (irst) begin
      pipe[0] = '{0, 0, 0};
      pipe[1] = '{0, 0, 0};
      m_fa = 0; m_fb = 0; m_stalls = 0;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = nx;
      m_fa = na; m_fb = nb;
      if (exp_st) m_stalls++;
    end
    @(negedge clk);
    chk("fwd_a", int'(fa), m_fa);
    chk("fwd_b", int'(fb), m_fb);
    chk("cnt16", int'(cnt), sat(m_stalls, 65535));
    chk("cnt2", int'(cnt2), sat(m_stalls, 3));
  endtask

  // ALU op: rd <= rs op rt
  task automatic alu(input int d, input int a, input int b);
    step(1, a, 1, b, 1, d, 1, 0, 0, 0);
  endtask

  task automatic lw(input int d, input int base);
    step(1, base, 1, d, 0, d, 1, 1, 0, 0);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pipe[0] = '{0, 0, 0};
    pipe[1] = '{0, 0, 0};
    m_fa = 0; m_fb = 0; m_stalls = 0;
    v = 0; rs = 0; rt = 0; urs = 0; urt = 0;
    rd = 0; rw = 0; mr = 0; fl = 0; rst = 1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_fa", int'(fa), 0);
    chk("rst_cnt", int'(cnt), 0);

    // back-to-back ALU dependency
    alu(1, 8, 9);
    alu(2, 1, 1);
    chk("b2b_a", int'(fa), 1);
    chk("b2b_b", int'(fb), 1);

    // distance-2 dependency, rs only
    alu(1, 8, 9);
    nop();
    step(1, 1, 1, 4, 0, 3, 1, 0, 0, 0);
    chk("d2_a", int'(fa), 2);
    chk("d2_b", int'(fb), 0);

    // load-use: one stall then MEM forward
    nop(); nop();
    lw(4, 10);
    alu(5, 4, 0);
    chk("lu_bub_a", int'(fa), 0);
    chk("lu_cnt", int'(cnt), 1);
    alu(5, 4, 0);
    chk("lu_fwd_a", int'(fa), 2);

    // double producer, EX wins; $0 never forwarded
    alu(5, 1, 2);
    alu(5, 1, 2);
    alu(6, 5, 5);
    chk("dbl_a", int'(fa), 1);
    chk("dbl_b", int'(fb), 1);
    alu(0, 1, 2);
    alu(7, 0, 0);
    chk("r0_a", int'(fa), 0);
    chk("r0_b", int'(fb), 0);

    // flush beats stall
    lw(7, 1);
    step(1, 7, 1, 7, 1, 8, 1, 0, 1, 0);
    chk("fl_cnt", int'(cnt), 1);
    chk("fl_a", int'(fa), 0);

    // reset during the stall cycle
    lw(4, 10);
    step(1, 4, 1, 0, 1, 5, 1, 0, 0, 1);
    alu(5, 4, 0);
    chk("rs_cnt", int'(cnt), 0);
    chk("rs_a", int'(fa), 0);

    // five separate load-use stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      lw(3, 1);
      alu(6, 3, 2);
      alu(6, 3, 2);
    end
    chk("sat2", int'(cnt2), 3);
    chk("sat16", int'(cnt), 5);

    // random streams over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 9) == 0),
           bit'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
